// File: rtl/adpcm_stream_ctrl_pkg.sv
// Shared types and constants for the ADPCM stream controller.
// FSM encoding, data widths and default sizing.
package adpcm_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_DRAIN
  } state_t;

  localparam int CODE_W = 4;
  localparam int BYTE_W = 8;

  localparam int DEF_DIV        = 16;
  localparam int DEF_WARMUP     = 8;
  localparam int DEF_FIFO_DEPTH = 8;

endpackage

// File: rtl/adpcm_stream_ctrl_if.sv
// Byte stream handshake between the controller and
// the downstream consumer.
interface adpcm_stream_ctrl_if;
  import adpcm_ctrl_pkg::*;

  logic [BYTE_W-1:0] byte_out;
  logic              byte_valid;
  logic              byte_ready;

  modport master (
    output byte_out,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_out,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/adpcm_byte_fifo.sv
// Small synchronous byte FIFO with wrapping pointers
// and a separate occupancy count.
module adpcm_byte_fifo
  import adpcm_ctrl_pkg::*;
#(
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  // a push at full only lands when the head leaves in the same cycle
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/adpcm_stream_ctrl.sv
// CIC->ADPCM sequencing: wrapper enable, slow tick,
// warm-up discard, nibble packing and byte buffering.
module adpcm_stream_ctrl
  import adpcm_ctrl_pkg::*;
#(
  parameter int DIV            = DEF_DIV,
  parameter int WARMUP_SAMPLES = DEF_WARMUP,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code_in,
  output logic              block_enable,
  output logic              slow_en,
  output logic              overflow,
  output logic              busy,
  adpcm_stream_ctrl_if.master bs
);

  localparam int DIV_W  = $clog2(DIV);
  localparam int WARM_W = $clog2(WARMUP_SAMPLES + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [WARM_W-1:0]   warm_cnt;
  logic                nibble_phase;
  logic [CODE_W-1:0]   low_nib;

  logic                div_wrap;
  logic                warm_last;
  logic                run_pair;
  logic                drain_pad;
  logic                push;
  logic [BYTE_W-1:0]   push_data;
  logic                pop;
  logic                drop;
  logic                full;
  logic                empty;
  logic [CNT_W-1:0]    fifo_cnt;

  assign div_wrap  = (div_cnt == DIV_W'(DIV - 1));
  assign warm_last = (warm_cnt == WARM_W'(WARMUP_SAMPLES - 1));
  assign run_pair  = (state == ST_RUN) && code_valid && nibble_phase;
  assign drain_pad = (state == ST_DRAIN) && nibble_phase;
  assign pop       = !empty && bs.byte_ready;
  assign drop      = push && full && !pop;

  always_comb begin
    push      = 1'b0;
    push_data = {{CODE_W{1'b0}}, low_nib};
    unique case (1'b1)
      run_pair: begin
        push      = 1'b1;
        push_data = {code_in, low_nib};
      end
      drain_pad: push = 1'b1;
      default:   ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      warm_cnt     <= '0;
      nibble_phase <= 1'b0;
      low_nib      <= '0;
      block_enable <= 1'b0;
      slow_en      <= 1'b0;
      overflow     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      slow_en <= 1'b0;
      if (drop) overflow <= 1'b1;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_WARMUP;
            block_enable <= 1'b1;
            busy         <= 1'b1;
            overflow     <= 1'b0;
            div_cnt      <= '0;
            warm_cnt     <= '0;
            nibble_phase <= 1'b0;
          end
        end
        ST_WARMUP: begin
          if (stop) begin
            state        <= ST_IDLE;
            block_enable <= 1'b0;
            busy         <= 1'b0;
            div_cnt      <= '0;
          end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            slow_en <= div_wrap;
            if (code_valid) begin
              warm_cnt <= warm_cnt + WARM_W'(1);
              if (warm_last) state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // the code arriving with stop is still packed
          if (code_valid) begin
            if (!nibble_phase) low_nib <= code_in;
            nibble_phase <= !nibble_phase;
          end
          if (stop) begin
            state        <= ST_DRAIN;
            block_enable <= 1'b0;
            div_cnt      <= '0;
          end else begin
            div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
            slow_en <= div_wrap;
          end
        end
        ST_DRAIN: begin
          nibble_phase <= 1'b0;
          if (fifo_cnt == '0 && !push) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  adpcm_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_data),
    .rdata (bs.byte_out),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  assign bs.byte_valid = !empty;

endmodule

// File: tb/tb_adpcm_stream_ctrl.sv
// Randomized scoreboard bench for adpcm_stream_ctrl with
// a transaction-level reference model.
module tb_adpcm_stream_ctrl;
  import adpcm_ctrl_pkg::*;

  localparam int DIVN  = 16;
  localparam int WARMN = 8;
  localparam int DEPTH = 8;

  localparam int M_IDLE  = 0;
  localparam int M_WARM  = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code_in = 4'h0;
  logic       block_enable;
  logic       slow_en;
  logic       overflow;
  logic       busy;

  adpcm_stream_ctrl_if bs();

  adpcm_stream_ctrl #(
    .DIV            (DIVN),
    .WARMUP_SAMPLES (WARMN),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .code_valid   (code_valid),
    .code_in      (code_in),
    .block_enable (block_enable),
    .slow_en      (slow_en),
    .overflow     (overflow),
    .busy         (busy),
    .bs           (bs)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model state
  int         m_mode = M_IDLE;
  int         m_occ  = 0;
  int         m_age  = 0;
  int         m_warm = 0;
  bit         m_ovf  = 1'b0;
  bit         m_pop;
  bit         m_push;
  logic [7:0] m_byte;
  logic [3:0] nibs[$];
  logic [7:0] sb[$];
  logic [7:0] rx[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = M_IDLE;
      m_occ  = 0;
      m_age  = 0;
      m_warm = 0;
      m_ovf  = 1'b0;
      nibs.delete();
      sb.delete();
    end else begin
      m_pop  = bs.byte_ready && (m_occ > 0);
      m_push = 1'b0;
      m_byte = 8'h00;
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode = M_WARM;
          m_age  = 0;
          m_warm = 0;
          m_ovf  = 1'b0;
          nibs.delete();
        end
        M_WARM: begin
          m_age++;
          if (stop) m_mode = M_IDLE;
          else if (code_valid) begin
            m_warm++;
            if (m_warm == WARMN) m_mode = M_RUN;
          end
        end
        M_RUN: begin
          m_age++;
          if (code_valid) nibs.push_back(code_in);
          if (nibs.size() == 2) begin
            m_byte = {nibs[1], nibs[0]};
            nibs.delete();
            m_push = 1'b1;
          end
          if (stop) m_mode = M_DRAIN;
        end
        default: begin
          if (nibs.size() == 1) begin
            m_byte = {4'h0, nibs[0]};
            nibs.delete();
            m_push = 1'b1;
          end else if (m_occ == 0) m_mode = M_IDLE;
        end
      endcase
      if (m_push) begin
        if (m_occ == DEPTH && !m_pop) m_ovf = 1'b1;
        else begin
          sb.push_back(m_byte);
          m_occ++;
        end
      end
      if (m_pop) m_occ--;
    end
  end

  bit         held_v = 1'b0;
  logic [7:0] held_b;
  logic [7:0] exp_b;
  bit         en_exp;

  always @(negedge clk) begin
    if (rst) held_v = 1'b0;
    else begin
      en_exp = (m_mode == M_WARM) || (m_mode == M_RUN);
      check("block_enable", block_enable, en_exp);
      check("busy", busy, m_mode != M_IDLE);
      check("slow_en", slow_en,
            en_exp && m_age > 0 && (m_age % DIVN) == 0);
      check("overflow", overflow, m_ovf);
      check("byte_valid", bs.byte_valid, m_occ > 0);
      if (held_v) check("byte_hold", bs.byte_out, held_b);
      held_v = bs.byte_valid && !bs.byte_ready;
      held_b = bs.byte_out;
      if (bs.byte_valid && bs.byte_ready) begin
        rx.push_back(bs.byte_out);
        if (sb.size() == 0)
          check("unexpected_byte", bs.byte_out, 32'hFFFF_FFFF);
        else begin
          exp_b = sb.pop_front();
          check("byte_out", bs.byte_out, exp_b);
        end
      end
    end
  end

  function automatic logic [31:0] rx_at(input int i);
    return (rx.size() > i) ? 32'(rx[i]) : 32'hFFFF_FFFF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send_code(input logic [3:0] c);
    code_valid = 1'b1;
    code_in    = c;
    tick();
    code_valid = 1'b0;
  endtask

  task automatic warm();
    for (int i = 0; i < WARMN; i++) send_code(4'($urandom_range(0, 15)));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle", busy, 0);
  endtask

  int ticks;

  initial begin
    bs.byte_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_byte_valid", bs.byte_valid, 0);
    check("rst_byte_out", bs.byte_out, 0);
    check("rst_block_en", block_enable, 0);
    check("rst_slow_en", slow_en, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);

    // divider
    pulse_start();
    ticks = 0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      check("div_tick", slow_en, (i == 16 || i == 32));
    end
    pulse_stop();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (slow_en) ticks++;
    end
    check("div_after_stop", ticks, 0);

    // warm-up and pack
    rx.delete();
    bs.byte_ready = 1'b1;
    pulse_start();
    for (int i = 1; i <= 12; i++) send_code(4'(i));
    pulse_stop();
    wait_idle(50);
    check("pack_cnt", rx.size(), 2);
    check("pack_b0", rx_at(0), 32'hA9);
    check("pack_b1", rx_at(1), 32'hCB);
    check("pack_ovf", overflow, 0);

    // odd count plus stop
    rx.delete();
    pulse_start();
    warm();
    send_code(4'd3);
    send_code(4'd5);
    send_code(4'd7);
    pulse_stop();
    wait_idle(50);
    check("odd_cnt", rx.size(), 2);
    check("odd_b0", rx_at(0), 32'h53);
    check("odd_b1", rx_at(1), 32'h07);

    // overflow
    rx.delete();
    bs.byte_ready = 1'b0;
    pulse_start();
    warm();
    for (int i = 0; i < 18; i++) send_code(4'(i));
    tick();
    check("ovf_set", overflow, 1);
    pulse_stop();
    tick();
    bs.byte_ready = 1'b1;
    wait_idle(50);
    check("ovf_cnt", rx.size(), 8);
    check("ovf_first", rx_at(0), 32'h10);
    check("ovf_last", rx_at(7), 32'hFE);
    check("ovf_sticky", overflow, 1);
    pulse_start();
    check("ovf_clear", overflow, 0);
    pulse_stop();
    wait_idle(20);

    // push and pop together at full
    rx.delete();
    bs.byte_ready = 1'b0;
    pulse_start();
    warm();
    for (int i = 0; i < 16; i++) send_code(4'(i));
    send_code(4'h1);
    code_valid    = 1'b1;
    code_in       = 4'h2;
    bs.byte_ready = 1'b1;
    tick();
    code_valid    = 1'b0;
    bs.byte_ready = 1'b0;
    tick();
    check("full_pp_ovf", overflow, 0);
    send_code(4'h3);
    send_code(4'h4);
    tick();
    check("full_pp_drop", overflow, 1);
    pulse_stop();
    bs.byte_ready = 1'b1;
    wait_idle(50);
    check("full_pp_cnt", rx.size(), 9);
    check("full_pp_last", rx_at(8), 32'h21);

    // backpressure
    rx.delete();
    pulse_start();
    warm();
    for (int i = 0; i < 64; i++) begin
      code_valid    = 1'b1;
      code_in       = 4'($urandom_range(0, 15));
      bs.byte_ready = i[0];
      tick();
    end
    code_valid = 1'b0;
    pulse_stop();
    bs.byte_ready = 1'b1;
    wait_idle(100);
    check("bp_cnt", rx.size(), 32);

    // stop during warm-up
    rx.delete();
    pulse_start();
    for (int i = 0; i < 3; i++) send_code(4'hF);
    pulse_stop();
    tick();
    check("warm_stop_busy", busy, 0);
    check("warm_stop_rx", rx.size(), 0);

    // start during run is ignored
    rx.delete();
    pulse_start();
    warm();
    for (int i = 0; i < 4; i++) send_code(4'(i + 4));
    pulse_start();
    for (int i = 0; i < 4; i++) send_code(4'(i + 8));
    pulse_stop();
    wait_idle(50);
    check("run_start_cnt", rx.size(), 4);
    check("run_start_b2", rx_at(2), 32'h98);

    // reset mid-run
    bs.byte_ready = 1'b0;
    pulse_start();
    warm();
    for (int i = 0; i < 6; i++) send_code(4'(i));
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rstrun_valid", bs.byte_valid, 0);
    check("rstrun_block_en", block_enable, 0);
    check("rstrun_busy", busy, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rstrun_valid2", bs.byte_valid, 0);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      start         = ($urandom_range(0, 19) == 0);
      stop          = ($urandom_range(0, 59) == 0);
      code_valid    = $urandom_range(0, 1) == 1;
      code_in       = 4'($urandom_range(0, 15));
      bs.byte_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    start      = 1'b0;
    code_valid = 1'b0;
    pulse_stop();
    bs.byte_ready = 1'b1;
    wait_idle(200);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
